// File: rtl/fpu_fpd_seq_if.sv
// Bundle of the signals around the FPU issue/writeback sequencer.
//
// Signal groups:
//   req*        issue handshake from decode (reqValid/reqReady) plus the micro-op
//               payload: opcode, operand mode, register IDs, operand values and
//               the architectural SR/FPUL/FPSCR sampled at issue.
//   fpu*        drive side toward the FPU datapath (opMode, idMode, regs, values,
//               control inputs) and the FPU result side (fpuValD, fpuRegD,
//               fpuModeD, fpuOut*).
//   wb*         writeback handshake to the register file (wbValid/wbReady) plus
//               the captured result payload.
//   busy        sequencer is not idle.
//
// Handshake rule for both req and wb: a beat transfers on a rising clock edge
// where valid and ready are both high; the payload must be stable while valid
// is high and ready is low, and valid may not be withdrawn until the beat
// transfers.
//
// Modports:
//   slave   the sequencer itself.
//   master  the environment around it (decode, FPU and register file).
interface fpu_fpd_seq_if;
    logic        reqValid;
    logic        reqReady;
    logic [7:0]  reqOp;
    logic [1:0]  reqMode;
    logic [6:0]  reqRegA;
    logic [6:0]  reqRegB;
    logic [6:0]  reqRegC;
    logic [63:0] reqValA;
    logic [63:0] reqValB;
    logic [63:0] reqValC;
    logic [31:0] ctlInSr;
    logic [31:0] ctlInFpul;
    logic [31:0] ctlInFpScr;

    logic [7:0]  fpuOpMode;
    logic [1:0]  fpuIdMode;
    logic [6:0]  fpuRegA;
    logic [6:0]  fpuRegB;
    logic [6:0]  fpuRegC;
    logic [63:0] fpuValA;
    logic [63:0] fpuValB;
    logic [63:0] fpuValC;
    logic [31:0] fpuSr;
    logic [31:0] fpuFpul;
    logic [31:0] fpuFpScr;

    logic [63:0] fpuValD;
    logic [6:0]  fpuRegD;
    logic [1:0]  fpuModeD;
    logic [31:0] fpuOutSr;
    logic [31:0] fpuOutFpul;
    logic [31:0] fpuOutFpScr;

    logic        wbValid;
    logic        wbReady;
    logic [63:0] wbVal;
    logic [6:0]  wbReg;
    logic [1:0]  wbMode;
    logic [31:0] wbSr;
    logic [31:0] wbFpul;
    logic [31:0] wbFpScr;

    logic        busy;

    modport slave (
        input  reqValid, reqOp, reqMode, reqRegA, reqRegB, reqRegC,
               reqValA, reqValB, reqValC, ctlInSr, ctlInFpul, ctlInFpScr,
               fpuValD, fpuRegD, fpuModeD, fpuOutSr, fpuOutFpul, fpuOutFpScr,
               wbReady,
        output reqReady,
               fpuOpMode, fpuIdMode, fpuRegA, fpuRegB, fpuRegC,
               fpuValA, fpuValB, fpuValC, fpuSr, fpuFpul, fpuFpScr,
               wbValid, wbVal, wbReg, wbMode, wbSr, wbFpul, wbFpScr,
               busy
    );

    modport master (
        output reqValid, reqOp, reqMode, reqRegA, reqRegB, reqRegC,
               reqValA, reqValB, reqValC, ctlInSr, ctlInFpul, ctlInFpScr,
               fpuValD, fpuRegD, fpuModeD, fpuOutSr, fpuOutFpul, fpuOutFpScr,
               wbReady,
        input  reqReady,
               fpuOpMode, fpuIdMode, fpuRegA, fpuRegB, fpuRegC,
               fpuValA, fpuValB, fpuValC, fpuSr, fpuFpul, fpuFpScr,
               wbValid, wbVal, wbReg, wbMode, wbSr, wbFpul, wbFpScr,
               busy
    );
endinterface

// File: rtl/fpu_fpd_seq.sv
// Issue/writeback sequencer for the double-precision FPU datapath.
//
// Accepts one FPU micro-op at a time over the req handshake, drives the FPU
// with the latched operands for an opcode-dependent number of cycles, captures
// the FPU result on the last of those cycles and offers it on the wb handshake.
//
// Ports:
//   clk        sole clock, rising edge.
//   reset      asynchronous, active-low reset.
//   bus        fpu_fpd_seq_if.slave: req, fpu and wb signal groups plus busy.
//   state_dbg  current FSM state (0 IDLE, 1 EXEC, 2 WB) for observation.
//
// Parameters LAT_* give the number of EXEC cycles per opcode class (1..15);
// every other opcode takes one cycle.
module fpu_fpd_seq #(
    parameter int LAT_ADD = 2,
    parameter int LAT_MUL = 2,
    parameter int LAT_MAC = 4,
    parameter int LAT_CNV = 2
) (
    input  logic             clk,
    input  logic             reset,
    fpu_fpd_seq_if.slave     bus,
    output logic [1:0]       state_dbg
);
    // Micro-op encoding shared with decode's UCMD_FPU_* table.
    localparam logic [7:0] UCMD_FPU_NONE  = 8'h00;
    localparam logic [7:0] UCMD_FPU_ADD   = 8'h01;
    localparam logic [7:0] UCMD_FPU_SUB   = 8'h02;
    localparam logic [7:0] UCMD_FPU_MUL   = 8'h03;
    localparam logic [7:0] UCMD_FPU_MAC   = 8'h04;
    localparam logic [7:0] UCMD_FPU_MSC   = 8'h05;
    localparam logic [7:0] UCMD_FPU_CNVSI = 8'h06;
    localparam logic [7:0] UCMD_FPU_CNVIS = 8'h07;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        ready;
    logic        accept;
    logic        capture;

    // Operand registers: written only on accept, so decode may change its
    // inputs freely once the op has been taken.
    logic [7:0]  op_q;
    logic [1:0]  mode_q;
    logic [6:0]  reg_a_q;
    logic [6:0]  reg_b_q;
    logic [6:0]  reg_c_q;
    logic [63:0] val_a_q;
    logic [63:0] val_b_q;
    logic [63:0] val_c_q;
    logic [31:0] sr_q;
    logic [31:0] fpul_q;
    logic [31:0] fpscr_q;

    // Writeback registers: written only on the final EXEC cycle.
    logic [63:0] wb_val_q;
    logic [6:0]  wb_reg_q;
    logic [1:0]  wb_mode_q;
    logic [31:0] wb_sr_q;
    logic [31:0] wb_fpul_q;
    logic [31:0] wb_fpscr_q;

    // EXEC cycle count for an opcode; unknown opcodes take one cycle.
    function automatic logic [3:0] op_lat(input logic [7:0] op);
        case (op)
            UCMD_FPU_ADD, UCMD_FPU_SUB:     op_lat = 4'(LAT_ADD);
            UCMD_FPU_MUL:                   op_lat = 4'(LAT_MUL);
            UCMD_FPU_MAC, UCMD_FPU_MSC:     op_lat = 4'(LAT_MAC);
            UCMD_FPU_CNVSI, UCMD_FPU_CNVIS: op_lat = 4'(LAT_CNV);
            default:                        op_lat = 4'd1;
        endcase
    endfunction

    // Next-state and handshake decode. Ready is also raised in WB while the
    // consumer takes the result, so a new op can follow without a bubble.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                ready  = 1'b1;
                accept = bus.reqValid;
                if (bus.reqValid) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = S_WB;
                end
            end
            S_WB: begin
                if (bus.wbReady) begin
                    ready     = 1'b1;
                    accept    = bus.reqValid;
                    state_nxt = bus.reqValid ? S_EXEC : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= op_lat(bus.reqOp) - 4'd1;
            end else if (state == S_EXEC && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= UCMD_FPU_NONE;
            mode_q  <= 2'd0;
            reg_a_q <= 7'd0;
            reg_b_q <= 7'd0;
            reg_c_q <= 7'd0;
            val_a_q <= 64'd0;
            val_b_q <= 64'd0;
            val_c_q <= 64'd0;
            sr_q    <= 32'd0;
            fpul_q  <= 32'd0;
            fpscr_q <= 32'd0;
        end else if (accept) begin
            op_q    <= bus.reqOp;
            mode_q  <= bus.reqMode;
            reg_a_q <= bus.reqRegA;
            reg_b_q <= bus.reqRegB;
            reg_c_q <= bus.reqRegC;
            val_a_q <= bus.reqValA;
            val_b_q <= bus.reqValB;
            val_c_q <= bus.reqValC;
            sr_q    <= bus.ctlInSr;
            fpul_q  <= bus.ctlInFpul;
            fpscr_q <= bus.ctlInFpScr;
        end
    end

    // Intermediate FPU outputs are ignored; only the last EXEC cycle counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_val_q   <= 64'd0;
            wb_reg_q   <= 7'd0;
            wb_mode_q  <= 2'd0;
            wb_sr_q    <= 32'd0;
            wb_fpul_q  <= 32'd0;
            wb_fpscr_q <= 32'd0;
        end else if (capture) begin
            wb_val_q   <= bus.fpuValD;
            wb_reg_q   <= bus.fpuRegD;
            wb_mode_q  <= bus.fpuModeD;
            wb_sr_q    <= bus.fpuOutSr;
            wb_fpul_q  <= bus.fpuOutFpul;
            wb_fpscr_q <= bus.fpuOutFpScr;
        end
    end

    assign bus.reqReady = ready;

    // The opcode is the only FPU input gated by state: outside EXEC the FPU
    // sees NONE while the operand lines keep their last values.
    assign bus.fpuOpMode = (state == S_EXEC) ? op_q : UCMD_FPU_NONE;
    assign bus.fpuIdMode = mode_q;
    assign bus.fpuRegA   = reg_a_q;
    assign bus.fpuRegB   = reg_b_q;
    assign bus.fpuRegC   = reg_c_q;
    assign bus.fpuValA   = val_a_q;
    assign bus.fpuValB   = val_b_q;
    assign bus.fpuValC   = val_c_q;
    assign bus.fpuSr     = sr_q;
    assign bus.fpuFpul   = fpul_q;
    assign bus.fpuFpScr  = fpscr_q;

    assign bus.wbValid = (state == S_WB);
    assign bus.wbVal   = wb_val_q;
    assign bus.wbReg   = wb_reg_q;
    assign bus.wbMode  = wb_mode_q;
    assign bus.wbSr    = wb_sr_q;
    assign bus.wbFpul  = wb_fpul_q;
    assign bus.wbFpScr = wb_fpscr_q;

    assign bus.busy  = (state != S_IDLE);
    assign state_dbg = state;
endmodule

// File: tb/tb_fpu_fpd_seq.sv
module tb_fpu_fpd_seq;
    localparam int LAT_ADD = 2;
    localparam int LAT_MUL = 2;
    localparam int LAT_MAC = 4;
    localparam int LAT_CNV = 2;

    localparam logic [7:0] OP_NONE  = 8'h00;
    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_SUB   = 8'h02;
    localparam logic [7:0] OP_MUL   = 8'h03;
    localparam logic [7:0] OP_MAC   = 8'h04;
    localparam logic [7:0] OP_MSC   = 8'h05;
    localparam logic [7:0] OP_CNVSI = 8'h06;
    localparam logic [7:0] OP_CNVIS = 8'h07;
    localparam logic [7:0] OP_CMPGT = 8'h09;
    localparam logic [6:0] UREG_ZZR = 7'h7F;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] state_dbg;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpu_fpd_seq_if bus();

    fpu_fpd_seq #(
        .LAT_ADD(LAT_ADD),
        .LAT_MUL(LAT_MUL),
        .LAT_MAC(LAT_MAC),
        .LAT_CNV(LAT_CNV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .state_dbg(state_dbg)
    );

    // ---------------- FPU model ----------------
    // Results appear only on the cycle where the op has been presented for its
    // full latency; before and after that the model drives junk.
    int fpu_age;

    function automatic int model_lat(input logic [7:0] op);
        case (op)
            OP_ADD, OP_SUB:     return LAT_ADD;
            OP_MUL:             return LAT_MUL;
            OP_MAC, OP_MSC:     return LAT_MAC;
            OP_CNVSI, OP_CNVIS: return LAT_CNV;
            default:            return 1;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) fpu_age <= 0;
        else if (bus.fpuOpMode == OP_NONE) fpu_age <= 0;
        else fpu_age <= fpu_age + 1;
    end

    always_comb begin
        bus.fpuValD     = 64'hDEAD_BEEF_DEAD_BEEF;
        bus.fpuRegD     = 7'h55;
        bus.fpuModeD    = 2'b11;
        bus.fpuOutSr    = 32'hFFFF_FFFF;
        bus.fpuOutFpul  = 32'hFFFF_FFFF;
        bus.fpuOutFpScr = 32'hFFFF_FFFF;
        if (bus.fpuOpMode != OP_NONE && fpu_age == model_lat(bus.fpuOpMode) - 1) begin
            bus.fpuRegD     = bus.fpuRegC;
            bus.fpuModeD    = bus.fpuIdMode;
            bus.fpuOutSr    = bus.fpuSr;
            bus.fpuOutFpul  = bus.fpuFpul;
            bus.fpuOutFpScr = bus.fpuFpScr;
            case (bus.fpuOpMode)
                OP_ADD: bus.fpuValD = $realtobits($bitstoreal(bus.fpuValA) + $bitstoreal(bus.fpuValB));
                OP_SUB: bus.fpuValD = $realtobits($bitstoreal(bus.fpuValA) - $bitstoreal(bus.fpuValB));
                OP_MUL: bus.fpuValD = $realtobits($bitstoreal(bus.fpuValA) * $bitstoreal(bus.fpuValB));
                OP_MAC: bus.fpuValD = $realtobits($bitstoreal(bus.fpuValA) +
                                      $bitstoreal(bus.fpuValB) * $bitstoreal(bus.fpuValC));
                OP_MSC: bus.fpuValD = $realtobits($bitstoreal(bus.fpuValA) -
                                      $bitstoreal(bus.fpuValB) * $bitstoreal(bus.fpuValC));
                OP_CNVSI: bus.fpuValD = $realtobits($itor($signed(bus.fpuValA[31:0])));
                OP_CMPGT: begin
                    bus.fpuValD  = 64'd0;
                    bus.fpuRegD  = UREG_ZZR;
                    bus.fpuOutSr = {bus.fpuSr[31:1],
                                    ($bitstoreal(bus.fpuValA) > $bitstoreal(bus.fpuValB))};
                end
                default: bus.fpuValD = bus.fpuValA;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    // Entry layout: {val[63:0], reg[6:0], mode[1:0], sr, fpul, fpscr}
    logic [168:0] exp_q[$];
    int           due_q[$];
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic         in_beat = 1'b0;
    int           beat_start = 0;
    logic [168:0] e;
    int           due;

    always @(negedge clk) begin
        if (!reset) begin
            in_beat = 1'b0;
        end else if (bus.wbValid) begin
            if (!in_beat) begin
                in_beat    = 1'b1;
                beat_start = cyc;
            end
            if (bus.wbReady) begin
                in_beat = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_wb_beat", {63'd0, bus.wbValid}, 64'd0);
                end else begin
                    e   = exp_q.pop_front();
                    due = due_q.pop_front();
                    check("wb_latency", 64'(beat_start), 64'(due));
                    check("wbVal",   bus.wbVal,   e[168:105]);
                    check("wbReg",   64'(bus.wbReg),   64'(e[104:98]));
                    check("wbMode",  64'(bus.wbMode),  64'(e[97:96]));
                    check("wbSr",    64'(bus.wbSr),    64'(e[95:64]));
                    check("wbFpul",  64'(bus.wbFpul),  64'(e[63:32]));
                    check("wbFpScr", 64'(bus.wbFpScr), 64'(e[31:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [7:0] op, input logic [1:0] mode, input logic [6:0] rc,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [31:0] sr, input logic [31:0] fpul, input logic [31:0] fpscr,
                         input logic [63:0] e_val, input logic [6:0] e_reg, input logic [31:0] e_sr,
                         input int lat, output int acc);
        bus.reqValid   = 1'b1;
        bus.reqOp      = op;
        bus.reqMode    = mode;
        bus.reqRegA    = 7'd1;
        bus.reqRegB    = 7'd2;
        bus.reqRegC    = rc;
        bus.reqValA    = a;
        bus.reqValB    = b;
        bus.reqValC    = c;
        bus.ctlInSr    = sr;
        bus.ctlInFpul  = fpul;
        bus.ctlInFpScr = fpscr;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.reqReady) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            check("issue_timeout", {63'd0, bus.reqReady}, 64'd1);
        end else begin
            exp_q.push_back({e_val, e_reg, mode, e_sr, fpul, fpscr});
            due_q.push_back(acc + lat + 1);
        end
        @(posedge clk);
        #1;
        bus.reqValid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    int acc0, acc1, acc2;
    int mac_cycles;
    int seen;

    initial begin
        reset          = 1'b0;
        bus.reqValid   = 1'b0;
        bus.reqOp      = OP_NONE;
        bus.reqMode    = 2'd0;
        bus.reqRegA    = 7'd0;
        bus.reqRegB    = 7'd0;
        bus.reqRegC    = 7'd0;
        bus.reqValA    = 64'd0;
        bus.reqValB    = 64'd0;
        bus.reqValC    = 64'd0;
        bus.ctlInSr    = 32'd0;
        bus.ctlInFpul  = 32'd0;
        bus.ctlInFpScr = 32'd0;
        bus.wbReady    = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_reqReady",  64'(bus.reqReady),  64'd1);
        check("rst_wbValid",   64'(bus.wbValid),   64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_state",     64'(state_dbg),     64'd0);
        check("rst_fpuOpMode", 64'(bus.fpuOpMode), 64'(OP_NONE));
        check("rst_fpuValA",   bus.fpuValA,        64'd0);
        check("rst_wbVal",     bus.wbVal,          64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // ADD 1.0 + 2.0 -> 3.0 into register 5
        issue(OP_ADD, 2'b01, 7'd5, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'd0,
              32'h0000_00F0, 32'h1234_5678, 32'h0004_0001,
              64'h4008_0000_0000_0000, 7'd5, 32'h0000_00F0, LAT_ADD, acc0);
        drain();

        // SUB 3.0 - 1.0 -> 2.0, held in WB for 10 cycles by wbReady=0
        bus.wbReady = 1'b0;
        issue(OP_SUB, 2'b01, 7'd9, 64'h4008_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'd0,
              32'h0000_0001, 32'hCAFE_0000, 32'h0000_0002,
              64'h4000_0000_0000_0000, 7'd9, 32'h0000_0001, LAT_ADD, acc0);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (bus.wbValid) seen = 1;
        end
        check("stall_wb_arrived", 64'(seen), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("stall_wbValid",  64'(bus.wbValid),  64'd1);
            check("stall_wbVal",    bus.wbVal,         64'h4000_0000_0000_0000);
            check("stall_wbReg",    64'(bus.wbReg),    64'd9);
            check("stall_reqReady", 64'(bus.reqReady), 64'd0);
            check("stall_busy",     64'(bus.busy),     64'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.wbReady = 1'b1;
        @(negedge clk);
        check("wb_release_reqReady", 64'(bus.reqReady), 64'd1);
        @(negedge clk);
        check("after_wb_busy",    64'(bus.busy),    64'd0);
        check("after_wb_wbValid", 64'(bus.wbValid), 64'd0);
        check("after_wb_state",   64'(state_dbg),   64'd0);
        drain();

        // Back-to-back: ADD 1+2=3 then MUL 2*3=6, MUL accepted in ADD's WB cycle
        issue(OP_ADD, 2'b10, 7'd3, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'd0,
              32'h0000_0000, 32'h0000_0011, 32'h0000_0022,
              64'h4008_0000_0000_0000, 7'd3, 32'h0000_0000, LAT_ADD, acc1);
        issue(OP_MUL, 2'b11, 7'd4, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 64'd0,
              32'h0000_0300, 32'h0000_0033, 32'h0000_0044,
              64'h4018_0000_0000_0000, 7'd4, 32'h0000_0300, LAT_MUL, acc2);
        check("b2b_no_bubble", 64'(acc2), 64'(acc1 + LAT_ADD + 1));
        drain();

        // CMPGT 2.0 > 1.0 sets SR.T, result register is ZZR
        issue(OP_CMPGT, 2'b00, 7'd7, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'd0,
              32'h0000_0000, 32'h0000_0055, 32'h0000_0066,
              64'd0, UREG_ZZR, 32'h0000_0001, 1, acc0);
        drain();

        // MAC 1.0 + 2.0*3.0 -> 7.0; reqValC is clobbered after accept
        issue(OP_MAC, 2'b10, 7'd6, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000,
              64'h4008_0000_0000_0000, 32'h0000_0100, 32'h0000_0077, 32'h0000_0088,
              64'h401C_0000_0000_0000, 7'd6, 32'h0000_0100, LAT_MAC, acc0);
        bus.reqValC = 64'd0;
        mac_cycles  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.wbValid) break;
            if (bus.fpuOpMode == OP_MAC) mac_cycles++;
        end
        check("mac_opmode_cycles", 64'(mac_cycles), 64'(LAT_MAC));
        drain();

        // Reset pulse in the second EXEC cycle of a MAC aborts it
        issue(OP_MAC, 2'b01, 7'd2, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000,
              64'h4008_0000_0000_0000, 32'h0000_0200, 32'h0000_0099, 32'h0000_00AA,
              64'h401C_0000_0000_0000, 7'd2, 32'h0000_0200, LAT_MAC, acc0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        exp_q.delete();
        due_q.delete();
        check("abort_wbValid",   64'(bus.wbValid),   64'd0);
        check("abort_reqReady",  64'(bus.reqReady),  64'd1);
        check("abort_busy",      64'(bus.busy),      64'd0);
        check("abort_state",     64'(state_dbg),     64'd0);
        check("abort_fpuOpMode", 64'(bus.fpuOpMode), 64'(OP_NONE));
        check("abort_fpuValA",   bus.fpuValA,        64'd0);
        check("abort_fpuRegC",   64'(bus.fpuRegC),   64'd0);
        check("abort_fpuFpul",   64'(bus.fpuFpul),   64'd0);
        check("abort_wbVal",     bus.wbVal,          64'd0);
        check("abort_wbSr",      64'(bus.wbSr),      64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_wbValid", 64'(bus.wbValid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Recovery: CNVSI 5 -> 5.0
        issue(OP_CNVSI, 2'b00, 7'd8, 64'd5, 64'd0, 64'd0,
              32'h0000_0000, 32'h0000_00BB, 32'h0000_00CC,
              64'h4014_0000_0000_0000, 7'd8, 32'h0000_0000, LAT_CNV, acc0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fpu_fpd_seq.md
# fpu_fpd_seq

Issue/writeback sequencer for the double-precision FPU datapath. It accepts one FPU micro-op at a time from decode over a valid/ready handshake and drives the FPU's opMode, register-ID and operand inputs. It holds them stable for an opcode-dependent number of cycles, captures the FPU's destination value, register, mode and SR/FPUL/FPSCR outputs, and presents them to the register-file writeback over a second valid/ready handshake.

## Interface
Parameters:
- LAT_ADD, default 2: cycles for UCMD_FPU_ADD and UCMD_FPU_SUB.
- LAT_MUL, default 2: cycles for UCMD_FPU_MUL.
- LAT_MAC, default 4: cycles for UCMD_FPU_MAC and UCMD_FPU_MSC.
- LAT_CNV, default 2: cycles for UCMD_FPU_CNVSI and UCMD_FPU_CNVIS.
- Every other opcode takes 1 cycle. All parameters are legal in the range 1..15.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- reqValid / reqReady  in / out  1 / 1  issue handshake.
- reqOp  in  8  UCMD_FPU_* opcode.
- reqMode  in  2  operand mode.
- reqRegA, reqRegB, reqRegC  in  7 each  register IDs.
- reqValA, reqValB, reqValC  in  64 each  operand values.
- ctlInSr, ctlInFpul, ctlInFpScr  in  32 each  architectural SR/FPUL/FPSCR, sampled at issue.
- fpuOpMode  out  8  FPU opcode.
- fpuIdMode  out  2  FPU operand mode.
- fpuRegA/B/C  out  7 each  FPU register IDs.
- fpuValA/B/C  out  64 each  FPU operand values.
- fpuSr, fpuFpul, fpuFpScr  out  32 each  FPU control inputs.
- fpuValD  in  64  FPU result value.
- fpuRegD  in  7  FPU result register.
- fpuModeD  in  2  FPU result mode.
- fpuOutSr, fpuOutFpul, fpuOutFpScr  in  32 each  FPU control outputs.
- wbValid / wbReady  out / in  1 / 1  writeback handshake.
- wbVal  out  64  captured result value.
- wbReg  out  7  captured result register.
- wbMode  out  2  captured result mode.
- wbSr, wbFpul, wbFpScr  out  32 each  captured control values.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, EXEC, WB. A 4-bit down-counter `cnt` tracks the remaining EXEC cycles.
- reqReady = (state==IDLE) || (state==WB && wbReady). This is combinational and permits back-to-back issue.
- Accept occurs when reqValid && reqReady. On accept:
  - latch reqOp/Mode/Reg*/Val* and ctlIn* into operand registers;
  - set cnt = LAT(op) - 1;
  - go to EXEC.
- fpu* outputs are driven from the operand registers in EXEC. In IDLE and WB:
  - fpuOpMode = UCMD_FPU_NONE;
  - the other fpu* outputs hold their last latched values.
- EXEC, cnt != 0: decrement cnt.
- EXEC, cnt == 0: capture fpuValD, fpuRegD, fpuModeD and fpuOut* into the wb* registers, then go to WB.
- WB: wbValid = 1.
  - wbReady low: all wb* outputs hold.
  - wbReady high with an accept in the same cycle: go straight to EXEC.
  - wbReady high with no accept: go to IDLE.
- Compare ops and UCMD_FPU_NONE still produce a WB beat, with wbReg equal to whatever the FPU reports (UREG_ZZR). The consumer is responsible for dropping ZZR writes while still applying wbSr.
- Unknown opcodes use latency 1 and pass through the FPU result unchanged.
- Operand registers do not change between accept and the end of EXEC, so reqVal*/ctlIn* may change freely after the accept cycle.

## Timing
- Reset (reset==0, asynchronous):
  - state = IDLE, cnt = 0, busy = 0;
  - reqReady = 1, wbValid = 0;
  - all wb* = 0, fpuOpMode = UCMD_FPU_NONE, all other fpu* = 0.
- Reset asserted mid-EXEC or mid-WB aborts the op. No WB beat is emitted for it.
- Latency: an op accepted in cycle T has fpuOpMode valid in cycles T+1..T+LAT. wbValid rises in cycle T+LAT+1.
- Throughput, back-to-back with wbReady held high: one op per LAT+1 cycles.
- With wbReady low, the block stalls in WB indefinitely. reqReady stays 0 during that stall.
- The FPU result is sampled only on the final EXEC cycle. Intermediate FPU outputs are ignored.

## Test plan
- ADD: A=0x3FF0000000000000, B=0x4000000000000000, C-reg=5, LAT_ADD=2 → wbValid 3 cycles after accept, wbVal=0x4008000000000000, wbReg=5.
- Writeback stall: complete an op with wbReady=0 for 10 cycles → wbValid and wb* stable, reqReady=0, busy=1. Raise wbReady → IDLE next cycle.
- Back-to-back: a MUL issued while WB is handshaking in the same cycle → accepted without a bubble, and the second result is correct.
- CMPGT: A=0x4000000000000000, B=0x3FF0000000000000, ctlInSr=0 → latency 1, wbSr[0]=1, wbReg=UREG_ZZR.
- MAC with LAT_MAC=4: fpuOpMode=UCMD_FPU_MAC for exactly 4 cycles, then wbValid. Changing reqValC after accept does not affect wbVal.
- Reset pulse during cycle 2 of a MAC EXEC → all outputs return to reset values immediately, and no wbValid appears afterward.
